// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store port (m0) and a debug/DMA port (m1), with registered responses.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // Handshake: a master raises req with we/addr/wdata and holds all of them
    // stable until it sees gnt; gnt is a one-cycle pulse and the memory access
    // happens in that cycle. A req still high after gnt is a new request.
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [2:0]        dbg_state
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_M0   = 2'd1,
        GNT_M1   = 2'd2
    } gnt_e;

    gnt_e              state_q, state_d;
    logic              lw_q, lw_d;      // last winner: 0 = m0, 1 = m1
    logic              elig0, elig1;
    logic [ADDR_W-1:0] acc_addr_q;
    logic [DATA_W-1:0] acc_wdata_q;
    logic              acc_we_q;
    logic              granted;
    logic              aligned;

    assign dbg_state = {lw_q, state_q};

    // State register; the winner's fields are captured at the decision edge
    // so the memory port keeps the last address when nobody is granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= GNT_NONE;
            lw_q        <= 1'b1;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            acc_we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lw_q    <= lw_d;
            if (state_d == GNT_M0) begin
                acc_addr_q  <= m0_addr_i;
                acc_wdata_q <= m0_wdata_i;
                acc_we_q    <= m0_we_i;
            end else if (state_d == GNT_M1) begin
                acc_addr_q  <= m1_addr_i;
                acc_wdata_q <= m1_wdata_i;
                acc_we_q    <= m1_we_i;
            end
        end
    end

    // The master granted this cycle sits out the next decision.
    always_comb begin
        elig0   = m0_req_i && (state_q != GNT_M0);
        elig1   = m1_req_i && (state_q != GNT_M1);
        state_d = GNT_NONE;
        lw_d    = lw_q;
        if (elig0 && elig1) begin
            state_d = lw_q ? GNT_M0 : GNT_M1;
        end else if (elig0) begin
            state_d = GNT_M0;
        end else if (elig1) begin
            state_d = GNT_M1;
        end
        if (state_d == GNT_M0) begin
            lw_d = 1'b0;
        end else if (state_d == GNT_M1) begin
            lw_d = 1'b1;
        end
    end

    always_comb begin
        granted     = (state_q != GNT_NONE);
        aligned     = (acc_addr_q[1:0] == 2'b00);
        m0_gnt_o    = (state_q == GNT_M0);
        m1_gnt_o    = (state_q == GNT_M1);
        mem_addr_o  = acc_addr_q;
        mem_wdata_o = acc_wdata_q;
        mem_we_o    = granted && acc_we_q && aligned;
        mem_re_o    = granted && !acc_we_q && aligned;
    end

    // Responses land one cycle after the grant; a misaligned read returns zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m0_rvalid_o <= 1'b0;
            m0_err_o    <= 1'b0;
            m0_rdata_o  <= '0;
            m1_rvalid_o <= 1'b0;
            m1_err_o    <= 1'b0;
            m1_rdata_o  <= '0;
        end else begin
            m0_rvalid_o <= m0_gnt_o && !acc_we_q;
            m0_err_o    <= m0_gnt_o && !aligned;
            m1_rvalid_o <= m1_gnt_o && !acc_we_q;
            m1_err_o    <= m1_gnt_o && !aligned;
            if (m0_gnt_o && !acc_we_q) begin
                m0_rdata_o <= aligned ? mem_rdata_i : '0;
            end
            if (m1_gnt_o && !acc_we_q) begin
                m1_rdata_o <= aligned ? mem_rdata_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table, hand-written corner
// sequences, and queue-driven random traffic against a reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_re_o(mem_re),
        .mem_rdata_i(mem_rdata), .dbg_state(dbg_state)
    );

    // Memory seen by the DUT (64 words) and the model's own copy.
    logic [31:0] sim_mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        preload = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'd5 : (32'hA000_0000 + 32'(i));
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) sim_mem[i] <= init_word(i);
        end else if (mem_we) begin
            sim_mem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = sim_mem[mem_addr[7:2]];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        rst_i = 1'b1;
        preload = 1'b1;
        idle_inputs();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        @(posedge clk); #1;
        preload = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic [1:0]  gnt;   // {m1, m0}
        logic        we, re;
        logic [31:0] addr, wdata;
        logic [1:0]  rv, err;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t tbl [13];

    task automatic fill_table();
        tbl[0]  = '{1'b1,1'b0,32'h08,32'h0,  1'b0,1'b0,32'h0,32'h0,  2'b01, 1'b0,1'b1,32'h08,32'h0,  2'b00,2'b00, 32'h0,32'h0};
        tbl[1]  = '{1'b0,1'b0,32'h0,32'h0,   1'b0,1'b0,32'h0,32'h0,  2'b00, 1'b0,1'b0,32'h08,32'h0,  2'b01,2'b00, 32'h5,32'h0};
        tbl[2]  = '{1'b1,1'b1,32'h10,32'h11, 1'b1,1'b0,32'h14,32'h0, 2'b10, 1'b0,1'b1,32'h14,32'h0,  2'b00,2'b00, 32'h5,32'h0};
        tbl[3]  = '{1'b1,1'b1,32'h10,32'h11, 1'b0,1'b0,32'h0,32'h0,  2'b01, 1'b1,1'b0,32'h10,32'h11, 2'b10,2'b00, 32'h5,32'hA000_0005};
        tbl[4]  = '{1'b1,1'b0,32'h10,32'h0,  1'b1,1'b0,32'h0e,32'h0, 2'b10, 1'b0,1'b0,32'h0e,32'h0,  2'b00,2'b00, 32'h5,32'hA000_0005};
        tbl[5]  = '{1'b1,1'b0,32'h10,32'h0,  1'b0,1'b0,32'h0,32'h0,  2'b01, 1'b0,1'b1,32'h10,32'h0,  2'b10,2'b10, 32'h5,32'h0};
        tbl[6]  = '{1'b1,1'b1,32'h0d,32'hFF, 1'b0,1'b0,32'h0,32'h0,  2'b00, 1'b0,1'b0,32'h10,32'h0,  2'b01,2'b00, 32'h11,32'h0};
        tbl[7]  = '{1'b1,1'b1,32'h0d,32'hFF, 1'b0,1'b0,32'h0,32'h0,  2'b01, 1'b0,1'b0,32'h0d,32'hFF, 2'b00,2'b00, 32'h11,32'h0};
        tbl[8]  = '{1'b0,1'b0,32'h0,32'h0,   1'b0,1'b0,32'h0,32'h0,  2'b00, 1'b0,1'b0,32'h0d,32'hFF, 2'b00,2'b01, 32'h11,32'h0};
        tbl[9]  = '{1'b1,1'b0,32'h08,32'h0,  1'b1,1'b0,32'h00,32'h0, 2'b10, 1'b0,1'b1,32'h00,32'h0,  2'b00,2'b00, 32'h11,32'h0};
        tbl[10] = '{1'b1,1'b0,32'h08,32'h0,  1'b1,1'b0,32'h04,32'h0, 2'b01, 1'b0,1'b1,32'h08,32'h0,  2'b10,2'b00, 32'h11,32'hA000_0000};
        tbl[11] = '{1'b0,1'b0,32'h0,32'h0,   1'b1,1'b0,32'h04,32'h0, 2'b10, 1'b0,1'b1,32'h04,32'h0,  2'b01,2'b00, 32'h5,32'hA000_0000};
        tbl[12] = '{1'b0,1'b0,32'h0,32'h0,   1'b0,1'b0,32'h0,32'h0,  2'b00, 1'b0,1'b0,32'h04,32'h0,  2'b10,2'b00, 32'h5,32'hA000_0001};
    endtask

    // ---------------- queue-driven traffic with reference model ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    txn_t cur0, cur1;
    int   glog[$];
    int   gcyc[$];

    task automatic load0(input int gap_pct);
        if (q0.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
            cur0 = q0.pop_front();
            m0_req = 1'b1; m0_we = cur0.we; m0_addr = cur0.addr; m0_wdata = cur0.wdata;
        end else begin
            m0_req = 1'b0;
        end
    endtask

    task automatic load1(input int gap_pct);
        if (q1.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
            cur1 = q1.pop_front();
            m1_req = 1'b1; m1_we = cur1.we; m1_addr = cur1.addr; m1_wdata = cur1.wdata;
        end else begin
            m1_req = 1'b0;
        end
    endtask

    // Expected behaviour from the arbitration rules: a master granted in the
    // previous cycle is skipped, a tie goes to whoever did not win last.
    task automatic run_queues(input int max_cyc, input int gap_pct);
        int          mg, mlw, ng, prev, pend_m;
        txn_t        pend, t;
        logic [31:0] mrd [2];
        logic [1:0]  exp_rv, exp_err;
        logic        al, e0, e1, done;
        mg = -1; mlw = 1; pend_m = -1; done = 1'b0;
        mrd[0] = '0; mrd[1] = '0;
        pend = '{1'b0, 32'h0, 32'h0};
        glog.delete(); gcyc.delete();
        load0(gap_pct);
        load1(gap_pct);
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(posedge clk); #1;
            exp_rv = 2'b00; exp_err = 2'b00;
            if (pend_m >= 0) begin
                al = (pend.addr[1:0] == 2'b00);
                if (!pend.we) begin
                    exp_rv[pend_m] = 1'b1;
                    mrd[pend_m] = al ? ref_mem[pend.addr[7:2]] : 32'h0;
                end
                exp_err[pend_m] = !al;
                if (pend.we && al) ref_mem[pend.addr[7:2]] = pend.wdata;
            end
            e0 = m0_req && (mg != 0);
            e1 = m1_req && (mg != 1);
            if (e0 && e1)  ng = 1 - mlw;
            else if (e0)   ng = 0;
            else if (e1)   ng = 1;
            else           ng = -1;
            chk1("rnd_gnt0", m0_gnt, ng == 0);
            chk1("rnd_gnt1", m1_gnt, ng == 1);
            chk1("rnd_rvalid0", m0_rvalid, exp_rv[0]);
            chk1("rnd_rvalid1", m1_rvalid, exp_rv[1]);
            chk1("rnd_err0", m0_err, exp_err[0]);
            chk1("rnd_err1", m1_err, exp_err[1]);
            chk32("rnd_rdata0", m0_rdata, mrd[0]);
            chk32("rnd_rdata1", m1_rdata, mrd[1]);
            if (ng >= 0) begin
                t = (ng == 0) ? cur0 : cur1;
                al = (t.addr[1:0] == 2'b00);
                chk32("rnd_mem_addr", mem_addr, t.addr);
                chk1("rnd_mem_we", mem_we, t.we && al);
                chk1("rnd_mem_re", mem_re, !t.we && al);
                if (t.we) chk32("rnd_mem_wdata", mem_wdata, t.wdata);
                glog.push_back(ng);
                gcyc.push_back(c);
                pend = t;
            end else begin
                chk1("rnd_idle_we", mem_we, 1'b0);
                chk1("rnd_idle_re", mem_re, 1'b0);
            end
            pend_m = ng;
            prev = mg;
            mg = ng;
            if (ng >= 0) mlw = ng;
            if (prev == 0 || !m0_req) load0(gap_pct);
            if (prev == 1 || !m1_req) load1(gap_pct);
            done = (q0.size() == 0) && (q1.size() == 0) && !m0_req && !m1_req && (pend_m < 0);
        end
        chk1("drain_within_budget", done, 1'b1);
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.we = 1'($urandom_range(0, 1));
        t.addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        if ($urandom_range(0, 7) == 0) t.addr[1:0] = 2'($urandom_range(1, 3));
        t.wdata = $urandom;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held.
        rst_i = 1'b1;
        idle_inputs();
        #1;
        chk1("rst_gnt0", m0_gnt, 1'b0);
        chk1("rst_gnt1", m1_gnt, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_mem_re", mem_re, 1'b0);
        chk1("rst_rvalid0", m0_rvalid, 1'b0);
        chk1("rst_rvalid1", m1_rvalid, 1'b0);
        chk1("rst_err0", m0_err, 1'b0);
        chk1("rst_err1", m1_err, 1'b0);
        chk32("rst_rdata0", m0_rdata, 32'h0);
        chk32("rst_rdata1", m1_rdata, 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_lw_is_m1", dbg_state[2], 1'b1);

        // Table: single read, round-robin, overlap, misaligned read/write.
        do_reset();
        fill_table();
        for (int i = 0; i < 13; i++) begin
            m0_req = tbl[i].r0; m0_we = tbl[i].w0; m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0;
            m1_req = tbl[i].r1; m1_we = tbl[i].w1; m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1;
            @(posedge clk); #1;
            chk1($sformatf("tbl%0d_gnt0", i), m0_gnt, tbl[i].gnt[0]);
            chk1($sformatf("tbl%0d_gnt1", i), m1_gnt, tbl[i].gnt[1]);
            chk1($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].we);
            chk1($sformatf("tbl%0d_mem_re", i), mem_re, tbl[i].re);
            chk32($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].addr);
            chk32($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].wdata);
            chk1($sformatf("tbl%0d_rvalid0", i), m0_rvalid, tbl[i].rv[0]);
            chk1($sformatf("tbl%0d_rvalid1", i), m1_rvalid, tbl[i].rv[1]);
            chk1($sformatf("tbl%0d_err0", i), m0_err, tbl[i].err[0]);
            chk1($sformatf("tbl%0d_err1", i), m1_err, tbl[i].err[1]);
            chk32($sformatf("tbl%0d_rdata0", i), m0_rdata, tbl[i].rd0);
            chk32($sformatf("tbl%0d_rdata1", i), m1_rdata, tbl[i].rd1);
        end
        chk32("tbl_mem_0x10_written", sim_mem[4], 32'h11);
        chk32("tbl_mem_0x0c_untouched", sim_mem[3], 32'hA000_0003);

        // Reset asserted during an m1 read grant.
        do_reset();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
        @(posedge clk); #1;
        chk1("rstmid_gnt1_before", m1_gnt, 1'b1);
        chk1("rstmid_re_before", mem_re, 1'b1);
        rst_i = 1'b1;
        #1;
        chk1("rstmid_gnt1_dropped", m1_gnt, 1'b0);
        chk1("rstmid_re_dropped", mem_re, 1'b0);
        chk1("rstmid_lw_m1", dbg_state[2], 1'b1);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h24;
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk); #1;
        chk1("rstmid_no_rvalid1", m1_rvalid, 1'b0);
        chk1("rstmid_tie_gnt0", m0_gnt, 1'b1);
        chk1("rstmid_tie_not_gnt1", m1_gnt, 1'b0);
        m0_req = 1'b0;
        @(posedge clk); #1;
        chk1("rstmid_then_gnt1", m1_gnt, 1'b1);
        chk1("rstmid_rvalid0", m0_rvalid, 1'b1);
        chk32("rstmid_rdata0", m0_rdata, 32'hA000_0009);
        m1_req = 1'b0;
        @(posedge clk); #1;
        chk1("rstmid_rvalid1", m1_rvalid, 1'b1);
        chk32("rstmid_rdata1", m1_rdata, 32'hA000_0008);

        // Contention: both masters with four reads each, no gaps.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{1'b0, 32'(4 * i), 32'h0});
            q1.push_back('{1'b0, 32'(32 + 4 * i), 32'h0});
        end
        run_queues(40, 0);
        chk32("rr_grant_count", 32'(glog.size()), 32'd8);
        if (glog.size() == 8) begin
            chk32("rr_first_cycle", 32'(gcyc[0]), 32'd0);
            for (int i = 0; i < 8; i++) begin
                chk32($sformatf("rr_winner%0d", i), 32'(glog[i]), 32'(i % 2));
                chk32($sformatf("rr_cycle%0d", i), 32'(gcyc[i]), 32'(i));
            end
        end

        // Back-to-back writes from m1 alone.
        do_reset();
        q1.push_back('{1'b1, 32'h10, 32'd7});
        q1.push_back('{1'b1, 32'h14, 32'd8});
        q1.push_back('{1'b1, 32'h18, 32'd9});
        run_queues(40, 0);
        chk32("b2b_grant_count", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) begin
            for (int i = 0; i < 3; i++) chk32($sformatf("b2b_winner%0d", i), 32'(glog[i]), 32'd1);
            chk32("b2b_spacing0", 32'(gcyc[1] - gcyc[0]), 32'd2);
            chk32("b2b_spacing1", 32'(gcyc[2] - gcyc[1]), 32'd2);
        end
        chk32("b2b_mem_0x10", sim_mem[4], 32'd7);
        chk32("b2b_mem_0x14", sim_mem[5], 32'd8);
        chk32("b2b_mem_0x18", sim_mem[6], 32'd9);

        // Random traffic with gaps against the model.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            q0.push_back(rand_txn());
            q1.push_back(rand_txn());
        end
        run_queues(3000, 30);
        for (int i = 0; i < 64; i++) chk32($sformatf("rnd_mem%0d", i), sim_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
